// File: rtl/int_param_sched.sv
// Interrupter parameter scheduler: soft-start ramp, burst gating and over-current lockout.
// Prescaled tick drives ramp/burst/decay timing; all outputs registered.
module int_param_sched #(
    parameter int CLK_MHZ     = 100,
    parameter int TICK_US     = 100,
    parameter int PAR_MAX_VAL = 255,
    parameter int FAULT_MAX   = 4,
    parameter int FAULT_DECAY = 8,
    localparam int W = $clog2(PAR_MAX_VAL + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] freq_tgt,
    input  logic [W-1:0] pw_tgt,
    input  logic [7:0]   burst_on,
    input  logic [7:0]   burst_off,
    input  logic         ocd_evt,
    input  logic         fault_clr,
    output logic [W-1:0] freq_par,
    output logic [W-1:0] pw_par,
    output logic         gate,
    output logic         fault,
    output logic [2:0]   state
);

    localparam int TICK_DIV = CLK_MHZ * TICK_US;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FC_W     = $clog2(FAULT_MAX + 1);
    localparam int DC_W     = (FAULT_DECAY > 1) ? $clog2(FAULT_DECAY) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RAMP    = 3'd1,
        S_RUN_ON  = 3'd2,
        S_RUN_OFF = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t          st;
    logic [PRE_W-1:0] pre;
    logic            tick;
    logic [FC_W-1:0] fcnt;
    logic [DC_W-1:0] dcnt;
    logic            trip;
    logic [7:0]      bcnt;

    assign tick  = (pre == PRE_W'(TICK_DIV - 1));
    assign trip  = (fcnt == FC_W'(FAULT_MAX));
    assign state = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Counter is frozen while locked out so the trip stays latched until cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt <= '0;
            dcnt <= '0;
        end else if (st == S_FAULT) begin
            if (fault_clr && !en) begin
                fcnt <= '0;
                dcnt <= '0;
            end
        end else if (ocd_evt) begin
            if (!trip) begin
                fcnt <= fcnt + 1'b1;
            end
            dcnt <= '0;
        end else if (tick) begin
            if (dcnt == DC_W'(FAULT_DECAY - 1)) begin
                dcnt <= '0;
                if (fcnt != '0) begin
                    fcnt <= fcnt - 1'b1;
                end
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= S_IDLE;
            freq_par <= '0;
            pw_par   <= '0;
            gate     <= 1'b0;
            fault    <= 1'b0;
            bcnt     <= '0;
        end else if (st != S_FAULT && trip) begin
            st       <= S_FAULT;
            freq_par <= '0;
            pw_par   <= '0;
            gate     <= 1'b0;
            fault    <= 1'b1;
        end else begin
            if (tick && st != S_FAULT) begin
                freq_par <= freq_tgt;
            end
            unique case (st)
                S_IDLE: begin
                    pw_par <= '0;
                    gate   <= 1'b0;
                    if (en) begin
                        st   <= S_RAMP;
                        gate <= 1'b1;
                    end
                end
                S_RAMP: begin
                    if (!en) begin
                        st     <= S_IDLE;
                        pw_par <= '0;
                        gate   <= 1'b0;
                    end else if (pw_par >= pw_tgt) begin
                        st     <= S_RUN_ON;
                        pw_par <= pw_tgt;
                        bcnt   <= burst_on;
                    end else if (tick) begin
                        pw_par <= pw_par + 1'b1;
                    end
                end
                S_RUN_ON: begin
                    if (!en) begin
                        st     <= S_IDLE;
                        pw_par <= '0;
                        gate   <= 1'b0;
                    end else if (pw_tgt > pw_par) begin
                        st <= S_RAMP;
                    end else begin
                        if (pw_tgt < pw_par) begin
                            pw_par <= pw_tgt;
                        end
                        // burst_on == 0 means continuous: the counter is never consulted.
                        if (burst_on != 8'd0 && tick) begin
                            if (bcnt <= 8'd1) begin
                                if (burst_off != 8'd0) begin
                                    st   <= S_RUN_OFF;
                                    gate <= 1'b0;
                                    bcnt <= burst_off;
                                end else begin
                                    bcnt <= burst_on;
                                end
                            end else begin
                                bcnt <= bcnt - 8'd1;
                            end
                        end
                    end
                end
                S_RUN_OFF: begin
                    if (!en) begin
                        st     <= S_IDLE;
                        pw_par <= '0;
                        gate   <= 1'b0;
                    end else if (tick) begin
                        if (bcnt <= 8'd1) begin
                            st   <= S_RUN_ON;
                            gate <= 1'b1;
                            bcnt <= burst_on;
                        end else begin
                            bcnt <= bcnt - 8'd1;
                        end
                    end
                end
                S_FAULT: begin
                    pw_par <= '0;
                    gate   <= 1'b0;
                    if (fault_clr && !en) begin
                        st    <= S_IDLE;
                        fault <= 1'b0;
                    end
                end
                default: begin
                    st     <= S_IDLE;
                    pw_par <= '0;
                    gate   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/int_param_sched.md
INT_PARAM_SCHED -- requirements
Module: int_param_sched

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have parameter CLK_MHZ, 100, clock frequency in MHz.
REQ-002 SHALL have parameter TICK_US, 100, scheduler tick period in µs; TICK_DIV = CLK_MHZ*TICK_US cycles.
REQ-003 SHALL have parameter PAR_MAX_VAL, 255, maximum freq/pw parameter value; parameter width W = clog2(PAR_MAX_VAL+1).
REQ-004 SHALL have parameter FAULT_MAX, 4, ocd count that trips lockout.
REQ-005 SHALL have parameter FAULT_DECAY, 8, ticks without ocd per fault-count decrement.
Ports (name, direction, width, meaning):
REQ-006 SHALL have clk, in, 1, single clock, rising edge.
REQ-007 SHALL have rst, in, 1, asynchronous active-high reset.
REQ-008 SHALL have en, in, 1, run request (level).
REQ-009 SHALL have freq_tgt, in, W, target freq_par.
REQ-010 SHALL have pw_tgt, in, W, target pw_par.
REQ-011 SHALL have burst_on, in, 8, burst on-time in ticks; 0 means continuous.
REQ-012 SHALL have burst_off, in, 8, burst off-time in ticks.
REQ-013 SHALL have ocd_evt, in, 1, single-cycle over-current pulse, already synchronous to clk.
REQ-014 SHALL have fault_clr, in, 1, lockout clear pulse.
REQ-015 SHALL have freq_par, out, W, interrupter frequency parameter (registered).
REQ-016 SHALL have pw_par, out, W, interrupter pulse-width parameter (registered).
REQ-017 SHALL have gate, out, 1, interrupter output enable (registered).
REQ-018 SHALL have fault, out, 1, lockout active (registered).
REQ-019 SHALL have state, out, 3, current FSM encoding.

Function
REQ-020 Prescaler SHALL count 0..TICK_DIV-1 free-running; tick is a 1-cycle pulse on the count TICK_DIV-1.
REQ-021 freq_par SHALL load freq_tgt on each tick while state is not FAULT; it is 0 in FAULT.
REQ-022 States SHALL be IDLE=0, RAMP=1, RUN_ON=2, RUN_OFF=3, FAULT=4.
REQ-023 IDLE: pw_par=0, gate=0; en=1 -> RAMP on the next edge.
REQ-024 RAMP: gate=1; pw_par increments by 1 on each tick while pw_par<pw_tgt; when pw_par>=pw_tgt, pw_par<=pw_tgt and -> RUN_ON with the burst counter loaded from burst_on.
REQ-025 RUN_ON: gate=1; a decrease of pw_tgt below pw_par SHALL be applied the next cycle; an increase SHALL return the FSM to RAMP.
REQ-026 RUN_ON with burst_on!=0: counter decrements per tick; on the tick reaching 0, -> RUN_OFF with counter=burst_off if burst_off!=0, else reload burst_on and stay.
REQ-027 RUN_OFF: gate=0, pw_par held; on the tick reaching 0, -> RUN_ON with counter=burst_on.
REQ-028 en=0 in RAMP/RUN_ON/RUN_OFF SHALL force IDLE next cycle (pw_par=0, gate=0).
REQ-029 Fault counter (saturating, 0..FAULT_MAX): +1 on ocd_evt; otherwise -1 after every FAULT_DECAY consecutive ocd-free ticks (floor 0); ocd_evt restarts the decay timer and wins over a same-cycle decrement.
REQ-030 Counter reaching FAULT_MAX SHALL force FAULT next cycle from any state, with priority over en and burst transitions.
REQ-031 FAULT: gate=0, pw_par=0, fault=1; exits to IDLE only on fault_clr=1 with en=0, clearing the fault counter and decay timer; fault_clr with en=1 is ignored.
REQ-032 ocd_evt in IDLE SHALL still count.
REQ-033 pw_tgt=0 in RAMP SHALL go to RUN_ON immediately with pw_par=0.

Reset
REQ-034 rst=1 SHALL asynchronously clear prescaler, burst counter, fault counter, decay timer, freq_par, pw_par, gate and fault, and set state=IDLE.
REQ-035 Reset deasserted mid-operation SHALL resume from IDLE; no tick occurs before TICK_DIV cycles after release.

Verification (CLK_MHZ=1, TICK_US=4, FAULT_MAX=4, FAULT_DECAY=8)
REQ-036 Ramp: en=1, pw_tgt=3 -> gate=1; pw_par steps 1,2,3 on consecutive ticks; state=2 after pw_par=3.
REQ-037 Burst: burst_on=2, burst_off=1, in RUN_ON -> gate high 2 ticks, low 1 tick, repeating; pw_par constant.
REQ-038 Fault trip: 4 ocd_evt pulses within 8 ticks -> FAULT, gate=0, pw_par=0, fault=1; fault_clr with en=1 -> no change; en=0 then fault_clr -> IDLE.
REQ-039 Decay: 3 ocd_evt, then 8 ocd-free ticks, then 2 ocd_evt -> counter ends at 4 -> FAULT; 1 ocd_evt instead -> counter 3, no fault.
REQ-040 Retarget/abort: RUN_ON pw_tgt 3->1 -> pw_par=1 next cycle; en=0 -> IDLE next cycle; rst pulse mid-RAMP -> all outputs 0 immediately.
